fifo_uart_tx: RTL and testbench

- Downstream consumer of the synchronous FIFO read port.
- Pops one B-bit word whenever the FIFO is non-empty and the block is enabled.
- Serialises each word onto a single line as an asynchronous-serial frame: start bit, B data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Sits between the FIFO and the off-chip/inter-block serial link. Paces the FIFO so that no words are lost.

---
 rtl/fifo_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pulls words from a synchronous FIFO read port and sends each one as an
// asynchronous-serial frame:
//   start bit (0), B data bits LSB first, optional parity bit, 1 or 2 stop bits.
// A word is popped only when the block is about to send it, so the FIFO is
// paced by the serial line and no word is lost.
//
// Parameters
//   B    : data word width (matches the FIFO data bus)
//   DIV  : clock cycles per serial bit (>= 2)
//   PAR  : 0 = no parity, 1 = even parity, 2 = odd parity
//   STOP : number of stop bits (1 or 2)
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   en        : 1 = may start new frames; 0 = finish current frame, then idle
//   emptyR    : FIFO empty flag
//   dataR     : FIFO read data, valid the cycle after enRd
//   enRd      : FIFO read enable, one pulse per word
//   txd       : serial line, idles high, registered
//   busy      : high whenever a frame is being fetched or sent
//   frameDone : one-cycle pulse in the last clock of the final stop bit
module fifo_uart_tx #(
   parameter int B    = 16,
   parameter int DIV  = 16,
   parameter int PAR  = 0,
   parameter int STOP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         emptyR,
   input  logic [B-1:0] dataR,
   output logic         enRd,
   output logic         txd,
   output logic         busy,
   output logic         frameDone
);

   localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int NW = (B > 1) ? $clog2(B) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   // frameDone is registered, so it is armed one cycle before the last clock
   localparam logic [BW-1:0] BAUD_PRE  = BW'(DIV - 2);
   localparam logic [NW-1:0] BIT_LAST  = NW'(B - 1);
   localparam logic          STOP_LAST = (STOP == 2);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP_ST
   } state_t;

   state_t         state_reg;
   logic [BW-1:0]  baud_reg;
   logic [NW-1:0]  bit_reg;
   logic           stop_reg;
   logic [B-1:0]   shift_reg;
   logic [B-1:0]   shift_next;
   logic           par_reg;
   logic           txd_reg;
   logic           done_reg;
   logic           baud_wrap;
   logic           start_ok;
   logic           timing;

   assign baud_wrap  = (baud_reg == BAUD_LAST);
   assign start_ok   = en & ~emptyR;
   assign shift_next = shift_reg >> 1;
   assign timing     = (state_reg == START) || (state_reg == DATA) ||
                       (state_reg == PARITY) || (state_reg == STOP_ST);

   assign enRd      = (state_reg == FETCH);
   assign busy      = (state_reg != IDLE);
   assign txd       = txd_reg;
   assign frameDone = done_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         stop_reg  <= 1'b0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         txd_reg   <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         // Baud counter free-runs only while a bit is on the line; it is held
         // at zero elsewhere so START always begins a full bit period.
         if (timing)
            baud_reg <= baud_wrap ? '0 : baud_reg + 1'b1;
         else
            baud_reg <= '0;

         done_reg <= (state_reg == STOP_ST) && (stop_reg == STOP_LAST) &&
                     (baud_reg == BAUD_PRE);

         case (state_reg)
            IDLE: begin
               txd_reg <= 1'b1;
               if (start_ok)
                  state_reg <= FETCH;
            end
            FETCH: begin
               // FIFO presents the word on the closing edge of this cycle
               state_reg <= LOAD;
            end
            LOAD: begin
               shift_reg <= dataR;
               par_reg   <= (PAR == 2) ? ~(^dataR) : ^dataR;
               txd_reg   <= 1'b0;
               state_reg <= START;
            end
            START: begin
               if (baud_wrap) begin
                  txd_reg   <= shift_reg[0];
                  bit_reg   <= '0;
                  state_reg <= DATA;
               end
            end
            DATA: begin
               if (baud_wrap) begin
                  if (bit_reg == BIT_LAST) begin
                     stop_reg <= 1'b0;
                     if (PAR != 0) begin
                        txd_reg   <= par_reg;
                        state_reg <= PARITY;
                     end else begin
                        txd_reg   <= 1'b1;
                        state_reg <= STOP_ST;
                     end
                  end else begin
                     shift_reg <= shift_next;
                     txd_reg   <= shift_next[0];
                     bit_reg   <= bit_reg + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (baud_wrap) begin
                  txd_reg   <= 1'b1;
                  stop_reg  <= 1'b0;
                  state_reg <= STOP_ST;
               end
            end
            STOP_ST: begin
               if (baud_wrap) begin
                  if (stop_reg == STOP_LAST) begin
                     // en and emptyR are only consulted here and in IDLE
                     state_reg <= start_ok ? FETCH : IDLE;
                  end else begin
                     stop_reg <= 1'b1;
                  end
               end
            end
            default: begin
               txd_reg   <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;

   always #5 clk = ~clk;

   // Three instances: u0 no parity / 1 stop, u1 even / 2 stop, u2 odd / 1 stop
   logic        empty0, empty1, empty2;
   logic [15:0] data0 = '0, data1 = '0, data2 = '0;
   logic        enrd0, enrd1, enrd2;
   logic        txd0, txd1, txd2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;

   // Behavioural FIFOs: pointers only grow, storage indexed modulo 64
   logic [15:0] mem0 [64];
   logic [15:0] mem1 [64];
   logic [15:0] mem2 [64];
   int wr0 = 0, wr1 = 0, wr2 = 0;
   int rd0 = 0, rd1 = 0, rd2 = 0;
   int bad0 = 0, bad1 = 0, bad2 = 0;

   assign empty0 = (wr0 == rd0);
   assign empty1 = (wr1 == rd1);
   assign empty2 = (wr2 == rd2);

   always @(posedge clk) if (enrd0) begin
      if (wr0 == rd0) bad0 <= bad0 + 1;
      else begin data0 <= mem0[rd0 % 64]; rd0 <= rd0 + 1; end
   end
   always @(posedge clk) if (enrd1) begin
      if (wr1 == rd1) bad1 <= bad1 + 1;
      else begin data1 <= mem1[rd1 % 64]; rd1 <= rd1 + 1; end
   end
   always @(posedge clk) if (enrd2) begin
      if (wr2 == rd2) bad2 <= bad2 + 1;
      else begin data2 <= mem2[rd2 % 64]; rd2 <= rd2 + 1; end
   end

   fifo_uart_tx #(.B(16), .DIV(4), .PAR(0), .STOP(1)) u0 (
      .clk(clk), .rst(rst), .en(en), .emptyR(empty0), .dataR(data0),
      .enRd(enrd0), .txd(txd0), .busy(busy0), .frameDone(done0));
   fifo_uart_tx #(.B(16), .DIV(4), .PAR(1), .STOP(2)) u1 (
      .clk(clk), .rst(rst), .en(en), .emptyR(empty1), .dataR(data1),
      .enRd(enrd1), .txd(txd1), .busy(busy1), .frameDone(done1));
   fifo_uart_tx #(.B(16), .DIV(3), .PAR(2), .STOP(1)) u2 (
      .clk(clk), .rst(rst), .en(en), .emptyR(empty2), .dataR(data2),
      .enRd(enrd2), .txd(txd2), .busy(busy2), .frameDone(done2));

   // Selected-instance view used by the frame checker
   int   sel = 0;
   logic m_enrd, m_txd, m_busy, m_done, m_empty;
   always_comb begin
      m_enrd = enrd0; m_txd = txd0; m_busy = busy0; m_done = done0; m_empty = empty0;
      if (sel == 1) begin
         m_enrd = enrd1; m_txd = txd1; m_busy = busy1; m_done = done1; m_empty = empty1;
      end else if (sel == 2) begin
         m_enrd = enrd2; m_txd = txd2; m_busy = busy2; m_done = done2; m_empty = empty2;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int div_of(input int s);
      return (s == 2) ? 3 : 4;
   endfunction
   function automatic int stop_of(input int s);
      return (s == 1) ? 2 : 1;
   endfunction

   // Reference frame: bit i of fr is the line level during serial bit i
   function automatic void make_frame(input logic [15:0] w, input int par, input int stp,
                                      output logic [19:0] fr, output int nb);
      fr    = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 16; i++) fr[i + 1] = w[i];
      nb = 17;
      if (par != 0) begin
         fr[17] = (par == 1) ? ^w : ~(^w);
         nb     = 18;
      end
      nb = nb + stp;
   endfunction

   task automatic push(input int s, input logic [15:0] w);
      case (s)
         0: begin mem0[wr0 % 64] = w; wr0++; end
         1: begin mem1[wr1 % 64] = w; wr1++; end
         default: begin mem2[wr2 % 64] = w; wr2++; end
      endcase
   endtask

   // Called at a negedge. Follows one frame from the FETCH cycle through the
   // last stop cycle, checking the line every clock. imm demands that the
   // pop happens on the very next cycle (back-to-back frames).
   task automatic check_frame(input int s, input logic [15:0] w, input logic [19:0] fr,
                              input int nb, input bit imm);
      int waited = 0;
      int div;
      bit last;
      sel = s;
      div = div_of(s);
      @(negedge clk);
      while (!m_enrd && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk($sformatf("u%0d_fetch_enrd", s), 32'(m_enrd), 32'd1);
      if (imm) chk($sformatf("u%0d_b2b_gap", s), 32'(waited), 32'd0);
      chk($sformatf("u%0d_fetch_txd", s), 32'(m_txd), 32'd1);
      @(negedge clk);
      chk($sformatf("u%0d_load_enrd", s), 32'(m_enrd), 32'd0);
      chk($sformatf("u%0d_load_txd", s), 32'(m_txd), 32'd1);
      chk($sformatf("u%0d_load_busy", s), 32'(m_busy), 32'd1);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < div; c++) begin
            @(negedge clk);
            last = (b == nb - 1) && (c == div - 1);
            chk($sformatf("u%0d_txd_bit%0d_clk%0d", s, b, c), 32'(m_txd), 32'(fr[b]));
            chk($sformatf("u%0d_done_bit%0d_clk%0d", s, b, c), 32'(m_done), 32'(last));
            chk($sformatf("u%0d_busy_bit%0d", s, b), 32'(m_busy), 32'd1);
            chk($sformatf("u%0d_enrd_bit%0d", s, b), 32'(m_enrd), 32'd0);
         end
      end
      $display("frame u%0d word %04h nbits %0d sent", s, w, nb);
   endtask

   typedef struct {
      int          sel;
      logic [15:0] word;
      logic [19:0] frame;
      int          nbits;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [19:0] fr;
      int          nb;
      int          cnt;
      logic [15:0] w;
      logic [15:0] words [3];

      vecs[0] = '{0, 16'hA5C3, 20'h34B86, 18};
      vecs[1] = '{1, 16'h0001, 20'hE0002, 20};
      vecs[2] = '{2, 16'h0001, 20'h40002, 19};
      vecs[3] = '{1, 16'h0003, 20'hC0006, 20};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_txd", {29'd0, txd2, txd1, txd0}, 32'h7);
      chk("rst_enrd", {29'd0, enrd2, enrd1, enrd0}, 32'h0);
      chk("rst_busy", {29'd0, busy2, busy1, busy0}, 32'h0);
      chk("rst_done", {29'd0, done2, done1, done0}, 32'h0);
      rst = 1'b1;
      en  = 1'b1;
      @(negedge clk);

      // Empty FIFO: nothing may happen
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (enrd0 || enrd1 || enrd2 || !txd0 || !txd1 || !txd2 || busy0 || busy1 || busy2)
            cnt++;
      end
      chk("empty_quiet", 32'(cnt), 32'd0);

      // Table-driven single frames, each followed by return to idle
      for (int v = 0; v < 4; v++) begin
         push(vecs[v].sel, vecs[v].word);
         check_frame(vecs[v].sel, vecs[v].word, vecs[v].frame, vecs[v].nbits, 1'b0);
         @(negedge clk);
         chk($sformatf("vec%0d_busy_after", v), 32'(m_busy), 32'd0);
         chk($sformatf("vec%0d_txd_after", v), 32'(m_txd), 32'd1);
      end

      // Back-to-back frames queued while disabled, then released
      en = 1'b0;
      words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
      for (int i = 0; i < 3; i++) push(0, words[i]);
      @(negedge clk);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         make_frame(words[i], 0, 1, fr, nb);
         check_frame(0, words[i], fr, nb, i != 0);
      end
      @(negedge clk);
      chk("b2b_busy_end", 32'(busy0), 32'd0);
      chk("b2b_fifo_empty", 32'(empty0), 32'd1);
      chk("b2b_pops", 32'(rd0), 32'd4);

      // en dropped mid-DATA: current frame completes, second word waits
      push(0, 16'h1111);
      push(0, 16'h2222);
      make_frame(16'h1111, 0, 1, fr, nb);
      fork
         check_frame(0, 16'h1111, fr, nb, 1'b0);
         begin
            repeat (12) @(negedge clk);
            en = 1'b0;
         end
      join
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (enrd0 || busy0 || !txd0) cnt++;
      end
      chk("endrop_idle", 32'(cnt), 32'd0);
      chk("endrop_word_kept", 32'(empty0), 32'd0);
      en = 1'b1;
      make_frame(16'h2222, 0, 1, fr, nb);
      check_frame(0, 16'h2222, fr, nb, 1'b0);

      // Reset mid-DATA: line high and idle immediately, popped word dropped
      push(0, 16'h1234);
      cnt = 0;
      while (!enrd0 && cnt < 40) begin @(negedge clk); cnt++; end
      chk("rstmid_pop", 32'(enrd0), 32'd1);
      repeat (10) @(negedge clk);
      chk("rstmid_in_data", 32'(busy0), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("rstmid_txd", 32'(txd0), 32'd1);
      chk("rstmid_busy", 32'(busy0), 32'd0);
      push(0, 16'h5A5A);
      repeat (3) @(negedge clk);
      chk("rstmid_hold", {30'd0, busy0, enrd0}, 32'd0);
      rst = 1'b1;
      make_frame(16'h5A5A, 0, 1, fr, nb);
      check_frame(0, 16'h5A5A, fr, nb, 1'b0);
      @(negedge clk);
      chk("rstmid_done_idle", 32'(busy0), 32'd0);

      // Randomised back-to-back traffic per instance against the frame model
      for (int s = 0; s < 3; s++) begin
         logic [15:0] q [$];
         int n;
         n = (s == 0) ? 8 : 4;
         en = 1'b0;
         @(negedge clk);
         for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            q.push_back(w);
            push(s, w);
         end
         en = 1'b1;
         for (int i = 0; i < n; i++) begin
            w = q.pop_front();
            make_frame(w, s, stop_of(s), fr, nb);
            check_frame(s, w, fr, nb, i != 0);
         end
         @(negedge clk);
         chk($sformatf("rand_u%0d_idle", s), 32'(m_busy), 32'd0);
         chk($sformatf("rand_u%0d_empty", s), 32'(m_empty), 32'd1);
      end

      chk("no_rd_when_empty", 32'(bad0 + bad1 + bad2), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
